// File: rtl/terminal_grid_writer_if.sv
// Command handshake between the keyboard/command front end (master) and the
// terminal grid writer (slave).
interface terminal_grid_writer_if #(
  parameter int CHAR_W = 5
);
  logic              cmd_valid_in;
  logic              cmd_ready_out;
  logic [1:0]        cmd_in;
  logic [CHAR_W-1:0] char_in;

  modport master (
    output cmd_valid_in,
    output cmd_in,
    output char_in,
    input  cmd_ready_out
  );

  modport slave (
    input  cmd_valid_in,
    input  cmd_in,
    input  char_in,
    output cmd_ready_out
  );
endinterface

// File: rtl/terminal_grid_writer.sv
// Character grid owner: writes codes at a managed cursor, handles newline,
// backspace, full clear and a row-per-cycle scroll-up past the last row.
module terminal_grid_writer #(
  parameter int ROWS   = 40,
  parameter int COLS   = 64,
  parameter int CHAR_W = 5
) (
  input  logic                                 pixel_clk_in,
  input  logic                                 rst_in,
  terminal_grid_writer_if.slave                cmd_if,
  output logic [ROWS-1:0][COLS-1:0][CHAR_W-1:0] terminal_grid,
  output logic [$clog2(ROWS)-1:0]              cursor_row_out,
  output logic [$clog2(COLS)-1:0]              cursor_col_out,
  output logic                                 busy_out
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [1:0] CMD_WRITE     = 2'b00;
  localparam logic [1:0] CMD_NEWLINE   = 2'b01;
  localparam logic [1:0] CMD_BACKSPACE = 2'b10;
  localparam logic [1:0] CMD_CLEAR     = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_SCROLL, ST_CLEAR} state_t;

  state_t        state;
  logic [RW-1:0] r_idx;
  logic [RW-1:0] cur_row;
  logic [CW-1:0] cur_col;
  logic          accept;

  assign cmd_if.cmd_ready_out = (state == ST_IDLE);
  assign busy_out             = (state != ST_IDLE);
  assign accept               = cmd_if.cmd_valid_in && (state == ST_IDLE);
  assign cursor_row_out       = cur_row;
  assign cursor_col_out       = cur_col;

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= ST_IDLE;
      r_idx         <= '0;
      cur_row       <= '0;
      cur_col       <= '0;
      terminal_grid <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (cmd_if.cmd_in)
              CMD_WRITE: begin
                terminal_grid[cur_row][cur_col] <= cmd_if.char_in;
                if (cur_col < LAST_COL) begin
                  cur_col <= cur_col + CW'(1);
                end else begin
                  cur_col <= '0;
                  // Running off the bottom row keeps the cursor there and scrolls.
                  if (cur_row < LAST_ROW) begin
                    cur_row <= cur_row + RW'(1);
                  end else begin
                    state <= ST_SCROLL;
                    r_idx <= '0;
                  end
                end
              end
              CMD_NEWLINE: begin
                cur_col <= '0;
                if (cur_row < LAST_ROW) begin
                  cur_row <= cur_row + RW'(1);
                end else begin
                  state <= ST_SCROLL;
                  r_idx <= '0;
                end
              end
              CMD_BACKSPACE: begin
                if (cur_col != '0) begin
                  cur_col <= cur_col - CW'(1);
                  terminal_grid[cur_row][cur_col - CW'(1)] <= '0;
                end else if (cur_row != '0) begin
                  cur_row <= cur_row - RW'(1);
                  cur_col <= LAST_COL;
                  terminal_grid[cur_row - RW'(1)][LAST_COL] <= '0;
                end
              end
              CMD_CLEAR: begin
                cur_row <= '0;
                cur_col <= '0;
                state   <= ST_CLEAR;
                r_idx   <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_SCROLL: begin
          // Rows 0..ROWS-2 take the row below; the final cycle blanks the last row.
          if (r_idx == LAST_ROW) begin
            terminal_grid[LAST_ROW] <= '0;
            r_idx <= '0;
            state <= ST_IDLE;
          end else begin
            terminal_grid[r_idx] <= terminal_grid[r_idx + RW'(1)];
            r_idx <= r_idx + RW'(1);
          end
        end
        ST_CLEAR: begin
          terminal_grid[r_idx] <= '0;
          if (r_idx == LAST_ROW) begin
            r_idx <= '0;
            state <= ST_IDLE;
          end else begin
            r_idx <= r_idx + RW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
